vga_timing_gen: RTL and testbench

- Display timing generator for the 640x480 @ 60 Hz VGA path.
- Produces the raster scan position (horz, vert) consumed by the icon drawer and map/colorizer stages, plus hsync/vsync/video_on for the VGA connector.
- Runs on the 100 MHz system clock and derives a 25 MHz pixel-rate enable internally.
- All raster outputs are registered, so downstream stages see stable coordinates for a full pixel period.

---
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the VGA timing generator to the draw/colorize
// stages and the VGA connector.
interface vga_timing_gen_if;
  logic       pix_tick;
  logic [9:0] horz;
  logic [9:0] vert;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;

  modport master (
    output pix_tick,
    output horz,
    output vert,
    output hsync,
    output vsync,
    output video_on,
    output frame_start
  );

  modport slave (
    input pix_tick,
    input horz,
    input vert,
    input hsync,
    input vsync,
    input video_on,
    input frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate enable, scan position,
// syncs and blanking, all registered off one state update.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 4,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // 11-bit bounds so a sync window ending at 1024 still compares.
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END =
    11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END =
    11'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  localparam logic SYNC_ON  = SYNC_ACTIVE;
  localparam logic SYNC_OFF = ~SYNC_ACTIVE;

  logic [3:0] div_q, div_d;
  logic [9:0] horz_q, horz_d;
  logic [9:0] vert_q, vert_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       vo_q, vo_d;
  logic       fs_q, fs_d;

  logic       tick;
  logic       h_wrap;
  logic       v_wrap;
  logic [10:0] h_ext;
  logic [10:0] v_ext;

  assign tick   = (div_q == DIV_LAST);
  assign h_wrap = (horz_q == H_LAST);
  assign v_wrap = (vert_q == V_LAST);
  assign h_ext  = {1'b0, horz_d};
  assign v_ext  = {1'b0, vert_d};

  always_comb begin
    div_d  = div_q + 4'd1;
    horz_d = horz_q;
    vert_d = vert_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    vo_d   = vo_q;
    fs_d   = 1'b0;

    if (tick) begin
      div_d = '0;

      if (h_wrap) begin
        horz_d = '0;
        vert_d = v_wrap ? '0 : vert_q + 10'd1;
      end else begin
        horz_d = horz_q + 10'd1;
      end

      // Decoded from the new position so syncs track coordinates.
      hs_d = (h_ext >= HS_BEG && h_ext < HS_END)
           ? SYNC_ON : SYNC_OFF;
      vs_d = (v_ext >= VS_BEG && v_ext < VS_END)
           ? SYNC_ON : SYNC_OFF;
      vo_d = (h_ext < H_VIS) && (v_ext < V_VIS);
      fs_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      horz_q <= H_LAST;
      vert_q <= V_LAST;
      hs_q   <= SYNC_OFF;
      vs_q   <= SYNC_OFF;
      vo_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      horz_q <= horz_d;
      vert_q <= vert_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      vo_q   <= vo_d;
      fs_q   <= fs_d;
    end
  end

  assign vga.pix_tick    = tick;
  assign vga.horz        = horz_q;
  assign vga.vert        = vert_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.video_on    = vo_q;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing plus a tiny
// raster with CLK_DIV=1 and active-high syncs for frame behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  vga_timing_gen_if ia();
  vga_timing_gen_if ib();

  vga_timing_gen u_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (ia)
  );

  vga_timing_gen #(
    .H_VISIBLE   (8),
    .H_FRONT     (2),
    .H_SYNC      (3),
    .H_BACK      (2),
    .V_VISIBLE   (6),
    .V_FRONT     (2),
    .V_SYNC      (2),
    .V_BACK      (3),
    .CLK_DIV     (1),
    .SYNC_ACTIVE (1'b1)
  ) u_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (ib)
  );

  typedef struct {
    int         n;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       fs;
  } vec_t;

  localparam int NV = 15;
  vec_t va[NV];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk_a(input string tag,
                       input int h, input int v,
                       input logic hs, input logic vs,
                       input logic vo, input logic pt,
                       input logic fs);
    chk({tag, ".horz"}, 32'(ia.horz), h);
    chk({tag, ".vert"}, 32'(ia.vert), v);
    chk({tag, ".hsync"}, 32'(ia.hsync), 32'(hs));
    chk({tag, ".vsync"}, 32'(ia.vsync), 32'(vs));
    chk({tag, ".video_on"}, 32'(ia.video_on), 32'(vo));
    chk({tag, ".pix_tick"}, 32'(ia.pix_tick), 32'(pt));
    chk({tag, ".frame_start"}, 32'(ia.frame_start), 32'(fs));
  endtask

  initial begin
    logic [9:0] p_h, p_v;
    logic       p_hs, p_vs, p_vo, p_pt;
    logic       r;
    int         p, eh, ev, k;
    int         hs_cnt, vs_cnt, fs_cnt, last_fs;
    logic       ehs, evs, evo, efs;

    rst_a = 1'b1;
    rst_b = 1'b1;

    //           n     h    v   hs vs vo pt fs
    va[0]  = '{   0, 799, 524, 1, 1, 0, 0, 0};
    va[1]  = '{   3, 799, 524, 1, 1, 0, 1, 0};
    va[2]  = '{   4,   0,   0, 1, 1, 1, 0, 1};
    va[3]  = '{   5,   0,   0, 1, 1, 1, 0, 0};
    va[4]  = '{   8,   1,   0, 1, 1, 1, 0, 0};
    va[5]  = '{2559, 638,   0, 1, 1, 1, 1, 0};
    va[6]  = '{2560, 639,   0, 1, 1, 1, 0, 0};
    va[7]  = '{2564, 640,   0, 1, 1, 0, 0, 0};
    va[8]  = '{2627, 655,   0, 1, 1, 0, 1, 0};
    va[9]  = '{2628, 656,   0, 0, 1, 0, 0, 0};
    va[10] = '{3011, 751,   0, 0, 1, 0, 1, 0};
    va[11] = '{3012, 752,   0, 1, 1, 0, 0, 0};
    va[12] = '{3203, 799,   0, 1, 1, 0, 1, 0};
    va[13] = '{3204,   0,   1, 1, 1, 1, 0, 0};
    va[14] = '{3208,   1,   1, 1, 1, 1, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    cyc   = 0;

    for (int i = 0; i < NV; i++) begin
      step_to(va[i].n);
      chk_a($sformatf("vec%0d_n%0d", i, va[i].n),
            int'(va[i].h), int'(va[i].v),
            va[i].hs, va[i].vs, va[i].vo,
            va[i].pt, va[i].fs);
    end

    // Reset mid-line on a pix_tick clock (horz=300, vert=1).
    step_to(4407);
    chk_a("pre_rst", 300, 1, 1, 1, 1, 1, 0);
    rst_a = 1'b1;
    step();
    chk_a("mid_rst", 799, 524, 1, 1, 0, 0, 0);
    rst_a = 1'b0;
    cyc   = 0;
    chk_a("rel0", 799, 524, 1, 1, 0, 0, 0);
    step();
    chk_a("rel1", 799, 524, 1, 1, 0, 0, 0);
    step();
    chk_a("rel2", 799, 524, 1, 1, 0, 0, 0);
    step();
    chk_a("rel3", 799, 524, 1, 1, 0, 1, 0);
    step();
    chk_a("rel4", 0, 0, 1, 1, 1, 0, 1);

    // Free run with sporadic resets; check hold, advance, decode.
    for (int i = 0; i < 6000; i++) begin
      p_h  = ia.horz;
      p_v  = ia.vert;
      p_hs = ia.hsync;
      p_vs = ia.vsync;
      p_vo = ia.video_on;
      p_pt = ia.pix_tick;
      r    = ($urandom_range(0, 799) == 0);
      rst_a = r;
      step();
      rst_a = 1'b0;
      if (r) begin
        chk_a("rnd_rst", 799, 524, 1, 1, 0, 0, 0);
      end else if (!p_pt) begin
        chk("hold.horz", 32'(ia.horz), 32'(p_h));
        chk("hold.vert", 32'(ia.vert), 32'(p_v));
        chk("hold.hsync", 32'(ia.hsync), 32'(p_hs));
        chk("hold.vsync", 32'(ia.vsync), 32'(p_vs));
        chk("hold.video_on", 32'(ia.video_on), 32'(p_vo));
        chk("hold.frame_start", 32'(ia.frame_start), 0);
      end else begin
        eh = (p_h == 10'd799) ? 0 : int'(p_h) + 1;
        ev = int'(p_v);
        if (p_h == 10'd799)
          ev = (p_v == 10'd524) ? 0 : int'(p_v) + 1;
        efs = (p_h == 10'd799) && (p_v == 10'd524);
        chk("adv.horz", 32'(ia.horz), eh);
        chk("adv.vert", 32'(ia.vert), ev);
        chk("adv.frame_start", 32'(ia.frame_start), 32'(efs));
      end
      evo = (ia.horz < 10'd640) && (ia.vert < 10'd480);
      ehs = !(ia.horz >= 10'd656 && ia.horz < 10'd752);
      evs = !(ia.vert >= 10'd490 && ia.vert < 10'd492);
      chk("inv.video_on", 32'(ia.video_on), 32'(evo));
      chk("inv.hsync", 32'(ia.hsync), 32'(ehs));
      chk("inv.vsync", 32'(ia.vsync), 32'(evs));
      chk("inv.horz_lt800", 32'(ia.horz < 10'd800), 1);
      chk("inv.vert_lt525", 32'(ia.vert < 10'd525), 1);
    end
    rst_a = 1'b1;

    // Tiny raster: 15x13, CLK_DIV=1, syncs active high.
    chk("b_rst.horz", 32'(ib.horz), 14);
    chk("b_rst.vert", 32'(ib.vert), 12);
    chk("b_rst.hsync", 32'(ib.hsync), 0);
    chk("b_rst.vsync", 32'(ib.vsync), 0);
    chk("b_rst.pix_tick", 32'(ib.pix_tick), 1);
    rst_b  = 1'b0;
    hs_cnt = 0;
    vs_cnt = 0;
    fs_cnt = 0;
    last_fs = -1;
    for (k = 1; k <= 400; k++) begin
      step();
      p   = k - 1;
      eh  = p % 15;
      ev  = (p / 15) % 13;
      efs = (p % 195 == 0);
      ehs = (eh >= 10 && eh <= 12);
      evs = (ev >= 8 && ev <= 9);
      evo = (eh < 8) && (ev < 6);
      chk("b.pix_tick", 32'(ib.pix_tick), 1);
      chk("b.horz", 32'(ib.horz), eh);
      chk("b.vert", 32'(ib.vert), ev);
      chk("b.hsync", 32'(ib.hsync), 32'(ehs));
      chk("b.vsync", 32'(ib.vsync), 32'(evs));
      chk("b.video_on", 32'(ib.video_on), 32'(evo));
      chk("b.frame_start", 32'(ib.frame_start), 32'(efs));
      if (p < 15 && ib.hsync) hs_cnt++;
      if (p < 195 && ib.vsync) vs_cnt++;
      if (ib.frame_start) begin
        if (last_fs >= 0)
          chk("b.fs_spacing", k - last_fs, 195);
        last_fs = k;
        fs_cnt++;
      end
    end
    chk("b.hsync_clks_per_line", hs_cnt, 3);
    chk("b.vsync_clks_per_frame", vs_cnt, 30);
    chk("b.frame_start_count", fs_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
